// File: rtl/rv_ex_pkg.sv
// Shared encodings and FSM state type for the execute stage.
package rv_ex_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load/store size funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } ex_state_e;

endpackage

// File: rtl/ex_shifter.sv
// Iterative shifter: moves up to SHIFT_STEP bits per cycle until the
// remaining amount reaches zero. 'done' flags the cycle whose step finishes.
module ex_shifter #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic                     start,
  input  logic [XLEN-1:0]          data,
  input  logic [$clog2(XLEN)-1:0]  amount,
  input  logic                     right,
  input  logic                     arith,
  output logic [XLEN-1:0]          result,
  output logic                     done
);

  localparam int AW = $clog2(XLEN);
  localparam logic [AW:0] STEP = (AW+1)'(SHIFT_STEP);

  logic [XLEN-1:0] data_q;
  logic [AW-1:0]   rem_q;
  logic            right_q;
  logic            arith_q;
  logic [AW:0]     step_amt;

  // Step size for this cycle: the full step, or whatever is left.
  always_comb begin
    step_amt = STEP;
    if ({1'b0, rem_q} < STEP) step_amt = {1'b0, rem_q};
    if (right_q) begin
      if (arith_q) result = $unsigned($signed(data_q) >>> step_amt);
      else         result = data_q >> step_amt;
    end else begin
      result = data_q << step_amt;
    end
    done = start && (rem_q != '0) && ({1'b0, rem_q} <= STEP);
  end

  // Operand capture on load, then one step per cycle while start is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      rem_q   <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      data_q  <= data;
      rem_q   <= amount;
      right_q <= right;
      arith_q <= arith;
    end else if (start && (rem_q != '0)) begin
      data_q <= result;
      rem_q  <= rem_q - step_amt[AW-1:0];
    end
  end

endmodule

// File: rtl/ex_stage.sv
// Handshaked RV32I/RV64I execute stage with iterative shifts.
//
//   state    | meaning
//   ST_IDLE  | empty, ready for a bundle
//   ST_SHIFT | shifter iterating, input blocked
//   ST_DONE  | result valid, held until out_ready
module ex_stage
  import rv_ex_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     ir,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     ir_res,
  output logic [XLEN-1:0] alu_res,
  output logic            comp_res,
  output logic [XLEN-1:0] pc_res,
  output logic [XLEN-1:0] b_res,
  output logic            illegal
);

  localparam int AW = $clog2(XLEN);

  ex_state_e       state;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] op2;
  logic [XLEN-1:0] d_alu;
  logic [XLEN-1:0] d_pc;
  logic            d_comp;
  logic            d_illegal;
  logic            d_shift;
  logic            d_right;
  logic            d_arith;
  logic [AW-1:0]   d_shamt;
  logic            f7_ok;
  logic            accept;
  logic            sh_load;
  logic [XLEN-1:0] sh_result;
  logic            sh_done;
  logic            unused_bits;

  assign opcode      = ir[6:0];
  assign f3          = ir[14:12];
  assign f7          = ir[31:25];
  assign unused_bits = ^{ir[24:15], ir[11:7]};

  assign in_ready  = rst_n && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign sh_load   = accept && d_shift && (d_shamt != '0);

  // Decode and single-cycle result for the bundle currently on the inputs.
  always_comb begin
    d_alu     = '0;
    d_comp    = 1'b0;
    d_pc      = pc + XLEN'(4);
    d_illegal = 1'b0;
    d_shift   = 1'b0;
    d_right   = 1'b0;
    d_arith   = 1'b0;
    op2       = (opcode == OP_REG) ? b : imm;
    d_shamt   = op2[AW-1:0];
    // RV64 immediate shifts carry shamt[5] in bit 25, so only six bits are funct.
    if ((opcode == OP_IMM) && (XLEN == 64))
      f7_ok = (ir[31:26] == 6'b000000) || (ir[31:26] == 6'b010000);
    else
      f7_ok = (f7 == F7_BASE) || (f7 == F7_ALT);

    case (opcode)
      OP_LUI:   d_alu = imm;
      OP_AUIPC: d_alu = pc + imm;
      OP_JAL: begin
        d_alu = pc + XLEN'(4);
        d_pc  = pc + imm;
      end
      OP_JALR: begin
        if (f3 == 3'b000) begin
          d_alu = pc + XLEN'(4);
          d_pc  = (a + imm) & ~XLEN'(1);
        end else begin
          d_illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        case (f3)
          F3_BEQ:  d_comp = (a == b);
          F3_BNE:  d_comp = (a != b);
          F3_BLT:  d_comp = ($signed(a) < $signed(b));
          F3_BGE:  d_comp = ($signed(a) >= $signed(b));
          F3_BLTU: d_comp = (a < b);
          F3_BGEU: d_comp = (a >= b);
          default: d_illegal = 1'b1;
        endcase
        if (d_comp) d_pc = pc + imm;
      end
      OP_LOAD: begin
        if ((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) ||
            (f3 == F3_HU) || ((XLEN == 64) && ((f3 == F3_D) || (f3 == F3_WU))))
          d_alu = a + imm;
        else
          d_illegal = 1'b1;
      end
      OP_STORE: begin
        if ((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || ((XLEN == 64) && (f3 == F3_D)))
          d_alu = a + imm;
        else
          d_illegal = 1'b1;
      end
      OP_IMM, OP_REG: begin
        // For OP_IMM the upper bits are immediate except on shifts.
        if (((opcode == OP_REG) || (f3 == F3_SLL) || (f3 == F3_SR)) && !f7_ok) begin
          d_illegal = 1'b1;
        end else begin
          case (f3)
            F3_ADD:  d_alu = ((opcode == OP_REG) && ir[30]) ? a - op2 : a + op2;
            F3_SLT: begin
              d_comp = ($signed(a) < $signed(op2));
              d_alu  = XLEN'(d_comp);
            end
            F3_SLTU: begin
              d_comp = (a < op2);
              d_alu  = XLEN'(d_comp);
            end
            F3_XOR:  d_alu = a ^ op2;
            F3_OR:   d_alu = a | op2;
            F3_AND:  d_alu = a & op2;
            F3_SLL:  d_shift = 1'b1;
            default: begin
              d_shift = 1'b1;
              d_right = 1'b1;
              d_arith = ir[30];
            end
          endcase
        end
      end
      default: d_illegal = 1'b1;
    endcase

    if (d_illegal) begin
      d_alu   = '0;
      d_comp  = 1'b0;
      d_pc    = pc + XLEN'(4);
      d_shift = 1'b0;
    end
  end

  ex_shifter #(
    .XLEN       (XLEN),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (sh_load),
    .start  (state == ST_SHIFT),
    .data   (a),
    .amount (d_shamt),
    .right  (d_right),
    .arith  (d_arith),
    .result (sh_result),
    .done   (sh_done)
  );

  // FSM and result registers; a zero-amount shift passes 'a' through directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ir_res   <= '0;
      alu_res  <= '0;
      comp_res <= 1'b0;
      pc_res   <= '0;
      b_res    <= '0;
      illegal  <= 1'b0;
    end else if (accept) begin
      ir_res   <= ir;
      alu_res  <= d_shift ? a : d_alu;
      comp_res <= d_comp;
      pc_res   <= d_pc;
      b_res    <= b;
      illegal  <= d_illegal;
      state    <= sh_load ? ST_SHIFT : ST_DONE;
    end else if ((state == ST_SHIFT) && sh_done) begin
      alu_res <= sh_result;
      state   <= ST_DONE;
    end else if ((state == ST_DONE) && out_ready) begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: 32-bit/step 1, 32-bit/step 8, 64-bit/step 4.
module tb_ex_stage;

  logic        clk;
  logic        rst_n;

  logic        in_valid, out_ready, in_ready, out_valid;
  logic [31:0] ir, imm, a, b, pc;
  logic [31:0] ir_res, alu_res, pc_res, b_res;
  logic        comp_res, illegal;

  logic        in_valid_b, out_ready_b, in_ready_b, out_valid_b;
  logic [31:0] ir_res_b, alu_res_b, pc_res_b, b_res_b;
  logic        comp_res_b, illegal_b;

  logic        in_valid_c, out_ready_c, in_ready_c, out_valid_c;
  logic [31:0] ir_c, ir_res_c;
  logic [63:0] imm_c, a_c, b_c, pc_c, alu_res_c, pc_res_c, b_res_c;
  logic        comp_res_c, illegal_c;

  int n_cmp = 0;
  int n_err = 0;

  ex_stage #(.XLEN(32), .SHIFT_STEP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ir(ir), .imm(imm), .a(a), .b(b), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready), .ir_res(ir_res),
    .alu_res(alu_res), .comp_res(comp_res), .pc_res(pc_res),
    .b_res(b_res), .illegal(illegal)
  );

  ex_stage #(.XLEN(32), .SHIFT_STEP(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .ir(ir), .imm(imm), .a(a), .b(b), .pc(pc),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .ir_res(ir_res_b),
    .alu_res(alu_res_b), .comp_res(comp_res_b), .pc_res(pc_res_b),
    .b_res(b_res_b), .illegal(illegal_b)
  );

  ex_stage #(.XLEN(64), .SHIFT_STEP(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .ir(ir_c), .imm(imm_c), .a(a_c), .b(b_c), .pc(pc_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .ir_res(ir_res_c),
    .alu_res(alu_res_c), .comp_res(comp_res_c), .pc_res(pc_res_c),
    .b_res(b_res_c), .illegal(illegal_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    in_valid_b = 1'b0; out_ready_b = 1'b1;
    in_valid_c = 1'b0; out_ready_c = 1'b1;
    ir = '0; imm = '0; a = '0; b = '0; pc = '0;
    ir_c = '0; imm_c = '0; a_c = '0; b_c = '0; pc_c = '0;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu", alu_res, 0);
    chk("rst_pc", pc_res, 0);
    chk("rst_ir", ir_res, 0);
    chk("rst_b", b_res, 0);
    chk("rst_comp", comp_res, 0);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // ADD wraps; back-to-back BLT/BLTU/SLT/illegal with out_ready high
    ir = 32'h002081B3; a = 32'hFFFFFFFF; b = 32'h1; pc = 32'h40; in_valid = 1'b1;
    tick();
    chk("add_valid", out_valid, 1);
    chk("add_alu", alu_res, 0);
    chk("add_pc", pc_res, 32'h44);
    chk("add_ir", ir_res, 32'h002081B3);
    chk("add_b", b_res, 1);
    chk("add_in_ready", in_ready, 1);

    ir = 32'h0020C063; pc = 32'h100; imm = 32'h20;
    tick();
    chk("blt_valid", out_valid, 1);
    chk("blt_comp", comp_res, 1);
    chk("blt_pc", pc_res, 32'h120);
    chk("blt_alu", alu_res, 0);

    ir = 32'h0020E063;
    tick();
    chk("bltu_comp", comp_res, 0);
    chk("bltu_pc", pc_res, 32'h104);

    ir = 32'h0020A1B3; pc = 32'h108;
    tick();
    chk("slt_alu", alu_res, 1);
    chk("slt_comp", comp_res, 1);
    chk("slt_pc", pc_res, 32'h10C);

    ir = 32'h0000007F; pc = 32'h110;
    tick();
    chk("ill_op_flag", illegal, 1);
    chk("ill_op_alu", alu_res, 0);
    chk("ill_op_comp", comp_res, 0);
    chk("ill_op_pc", pc_res, 32'h114);
    chk("ill_op_valid", out_valid, 1);

    ir = 32'h0020A063; a = 32'h1; b = 32'h1; pc = 32'h118; imm = 32'h20;
    tick();
    chk("ill_br_flag", illegal, 1);
    chk("ill_br_pc", pc_res, 32'h11C);

    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);

    // SLLI by zero: single-cycle pass-through
    ir = 32'h00009193; imm = 32'h0; a = 32'h1234; pc = 32'h120; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sh0_valid", out_valid, 1);
    chk("sh0_alu", alu_res, 32'h1234);
    chk("sh0_illegal", illegal, 0);
    tick();

    // SRAI 31 with SHIFT_STEP=1: 31 cycles, input blocked throughout
    ir = 32'h41F0D193; imm = 32'h41F; a = 32'h80000000; pc = 32'h130; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("srai_acc_in_ready", in_ready, 0);
    for (int i = 1; i < 31; i++) begin
      tick();
      chk("srai_busy_valid", out_valid, 0);
      chk("srai_busy_in_ready", in_ready, 0);
    end
    tick();
    chk("srai_valid", out_valid, 1);
    chk("srai_alu", alu_res, 32'hFFFFFFFF);
    chk("srai_pc", pc_res, 32'h134);
    tick();

    // Same SRAI on the SHIFT_STEP=8 instance: 4 cycles
    in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("srai8_busy_valid", out_valid_b, 0);
      chk("srai8_busy_in_ready", in_ready_b, 0);
    end
    tick();
    chk("srai8_valid", out_valid_b, 1);
    chk("srai8_alu", alu_res_b, 32'hFFFFFFFF);
    tick();

    // 64-bit SLL by 63 with SHIFT_STEP=4: ceil(63/4) = 16 cycles
    ir_c = 32'h002091B3; a_c = 64'h1; b_c = 64'd63; pc_c = 64'h1000; in_valid_c = 1'b1;
    tick();
    in_valid_c = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("sll64_busy_valid", out_valid_c, 0);
    end
    tick();
    chk("sll64_valid", out_valid_c, 1);
    chk("sll64_alu", alu_res_c, 64'h8000000000000000);
    chk("sll64_pc", pc_res_c, 64'h1004);
    tick();

    // JALR under back-pressure, then release with a bundle waiting
    ir = 32'h000080E7; a = 32'h1003; imm = 32'h0; pc = 32'h200; out_ready = 1'b0; in_valid = 1'b1;
    tick();
    chk("jalr_valid", out_valid, 1);
    chk("jalr_pc", pc_res, 32'h1002);
    chk("jalr_alu", alu_res, 32'h204);
    ir = 32'h002081B3; a = 32'h5; b = 32'h7; pc = 32'h300;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_pc", pc_res, 32'h1002);
      chk("bp_alu", alu_res, 32'h204);
      chk("bp_ir", ir_res, 32'h000080E7);
    end
    out_ready = 1'b1;
    #1;
    chk("rel_in_ready_comb", in_ready, 1);
    tick();
    chk("reload_valid", out_valid, 1);
    chk("reload_alu", alu_res, 32'hC);
    chk("reload_pc", pc_res, 32'h304);
    chk("reload_ir", ir_res, 32'h002081B3);
    in_valid = 1'b0;
    tick();
    chk("reload_drain", out_valid, 0);

    // Reset asserted mid-SHIFT discards the operation
    ir = 32'h00A09193; imm = 32'hA; a = 32'h3; b = 32'h9; pc = 32'h400; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("mid_shift_valid", out_valid, 0);
    rst_n = 1'b0;
    tick();
    chk("abort_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_alu", alu_res, 0);
    chk("abort_pc", pc_res, 0);
    chk("abort_ir", ir_res, 0);
    chk("abort_b", b_res, 0);
    chk("abort_comp", comp_res, 0);
    chk("abort_illegal", illegal, 0);
    rst_n = 1'b1;
    tick();
    chk("abort_rel_in_ready", in_ready, 1);
    chk("abort_rel_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Parametrised, handshaked execute stage for the RV32I/RV64I core. It sits between the decode/register-read stage and the memory stage, and replaces the fixed-width, always-ready execute FSM. Shifts are iterative and multi-cycle. Branch and jump next-PC values are resolved here. Unsupported encodings are flagged as illegal.

## Interface
Parameters:
- `XLEN`, default 32: datapath width; legal values are 32 or 64.
- `SHIFT_STEP`, default 1: bits shifted per cycle; must be a power of 2 and no greater than `XLEN`.

Ports (clock is `clk`; reset is synchronous and active-low, named `rst_n`):
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: operand bundle valid.
- `in_ready` output 1: stage can accept a bundle.
- `ir` input 32: instruction word.
- `imm` input `XLEN`: sign-extended immediate from decode.
- `a` input `XLEN`: rs1 value.
- `b` input `XLEN`: rs2 value.
- `pc` input `XLEN`: PC of the instruction.
- `out_valid` output 1: result bundle valid.
- `out_ready` input 1: downstream accepts the result.
- `ir_res` output 32: registered copy of `ir`.
- `alu_res` output `XLEN`: ALU, address or link result.
- `comp_res` output 1: branch-taken or set-less-than result.
- `pc_res` output `XLEN`: next PC.
- `b_res` output `XLEN`: registered `b`, used as store data.
- `illegal` output 1: encoding not supported.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
- `in_ready` is high in IDLE, and in DONE when `out_ready` is high. It is low in SHIFT and whenever `rst_n` is low.
- Accept happens on `in_valid && in_ready`. All inputs are captured on the accept edge; later input changes are ignored.
- Non-shift instruction: the result is computed combinationally and registered on accept, and the FSM goes to DONE.
- Shift instruction (SLL, SRL, SRA and their immediate forms): the shift amount is `imm` or `b` low log2(`XLEN`) bits.
  - A shift amount of 0 goes straight to DONE.
  - Otherwise the FSM enters SHIFT and sub-module `ex_shifter` shifts `min(SHIFT_STEP, remaining)` bits per cycle. It goes to DONE when remaining reaches 0.
  - SRA and SRAI fill with the sign bit.
- In DONE, `out_valid` is 1 and the outputs are held stable until `out_ready`. On `out_ready`, the FSM goes to IDLE, or reloads directly if a new bundle is accepted in the same cycle.
- Results (arithmetic is modulo 2^`XLEN`):
  - LUI: `alu_res` = `imm`.
  - AUIPC: `alu_res` = `pc` + `imm`.
  - JAL: `alu_res` = `pc` + 4; `pc_res` = `pc` + `imm`.
  - JALR: `alu_res` = `pc` + 4; `pc_res` = (`a` + `imm`) with bit 0 cleared.
  - Branches: `comp_res` = the condition (signed compare for BLT/BGE, unsigned for BLTU/BGEU). `pc_res` = `pc` + `imm` if taken, else `pc` + 4. `alu_res` = 0.
  - Loads and stores: `alu_res` = `a` + `imm`; `b_res` = `b`.
  - SLT, SLTI, SLTU, SLTIU: `alu_res` = zero-extended `comp_res`.
  - For all instructions other than jumps and branches, `pc_res` = `pc` + 4.
- Illegal encodings are an unknown opcode, an unknown funct3, or funct7 other than 0000000/0100000 where funct7 applies. The RV64 W-forms are also illegal. For an illegal encoding: `illegal` = 1, `alu_res` = 0, `comp_res` = 0, `pc_res` = `pc` + 4. Latency is the same as a non-shift instruction.

## Timing
- Reset values: state IDLE; `out_valid` 0; `ir_res`, `alu_res`, `pc_res`, `b_res` all 0; `comp_res` 0; `illegal` 0; `in_ready` 0 while `rst_n` is low and 1 on the first cycle after release.
- A reset asserted in SHIFT or DONE aborts the operation; the result is discarded.
- Latency, for an accept at edge N:
  - Non-shift, or a shift amount of 0: `out_valid` is high after edge N.
  - Shift with amount s > 0: `out_valid` is high after edge N + ceil(s / `SHIFT_STEP`).
- Throughput is one bundle per cycle for non-shift instructions while `out_ready` is held high.
- While `out_valid` is high and `out_ready` is low, all outputs are frozen and `in_ready` is 0.

## Structure
- Package `rv_ex_pkg` holds:
  - opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG);
  - the funct3 and funct7 constants;
  - the state enum type.
- Sub-module `ex_shifter` is parametrised by `XLEN` and `SHIFT_STEP`. It takes load, start, amount and direction/arithmetic inputs, and returns the result and a done flag.
- ALU decode stays inside `ex_stage`.

## Test plan
- ADD, `XLEN`=32: `a`=0xFFFFFFFF, `b`=1, with `out_ready` held high -> `alu_res`=0, `out_valid` one cycle after accept, `pc_res`=`pc`+4.
- BLT then BLTU with `a`=0xFFFFFFFF, `b`=1, `pc`=0x100, `imm`=0x20 -> BLT: `comp_res`=1, `pc_res`=0x120. BLTU: `comp_res`=0, `pc_res`=0x104.
- SRAI, `SHIFT_STEP`=1: `a`=0x80000000, shamt 31 -> `alu_res`=0xFFFFFFFF after 31 cycles, with `in_ready`=0 throughout. Repeat with `SHIFT_STEP`=8 -> 4 cycles.
- Back-pressure: hold `out_ready`=0 for 5 cycles after a JALR with `a`=0x1003, `imm`=0 -> outputs stable, `pc_res`=0x1002, no new accept. Then release `out_ready` with `in_valid` high -> the next bundle is accepted on the same edge.
- Illegal encoding: `ir`=0x0000007F -> `illegal`=1, `alu_res`=0. Separately, assert `rst_n` low mid-SHIFT -> next cycle `out_valid`=0, `in_ready`=0, and all outputs are 0.
- `XLEN`=64: SLL with `a`=1, `b`=63 -> `alu_res`=0x8000000000000000.
